// File: rtl/i2s_stereo_packer.sv
// rtl/i2s_stereo_packer.sv - pairs i2s_rx left/right words into MSB-aligned stereo frames behind a small FWFT FIFO
module i2s_stereo_packer #(
    parameter int OUT_WIDTH  = 24,
    parameter int MIN_BITS   = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [31:0]                   Audio,
    input  logic [4:0]                    channelBitCount,
    input  logic                          IsLeft,
    input  logic                          IsUpdate,
    output logic [OUT_WIDTH-1:0]          OutLeft,
    output logic [OUT_WIDTH-1:0]          OutRight,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
    output logic [7:0]                    DropCount,
    output logic                          Overflow,
    input  logic                          ClearStatus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {WAIT_LEFT, WAIT_RIGHT} state_t;

    state_t                state, state_next;
    logic [5:0]            len;
    logic [31:0]           aligned;
    logic [OUT_WIDTH-1:0]  sample;
    logic                  len_ok;
    logic [OUT_WIDTH-1:0]  held_left;
    logic [5:0]            held_len;
    logic                  load_held, drop_word, push_req;
    logic                  full, pop, push, ovf_evt, drop_evt;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [OUT_WIDTH-1:0]  mem_left  [FIFO_DEPTH];
    logic [OUT_WIDTH-1:0]  mem_right [FIFO_DEPTH];
    logic [OUT_WIDTH-1:0]  last_left, last_right;

    // Shifting the word up so bit L-1 sits at bit 31 makes both truncation and zero-fill fall out of one slice
    assign len     = {1'b0, channelBitCount} + 6'd1;
    assign aligned = Audio << (6'd32 - len);
    assign sample  = aligned[31 -: OUT_WIDTH];
    assign len_ok  = int'(len) >= MIN_BITS;

    always_comb begin
        state_next = state;
        load_held  = 1'b0;
        drop_word  = 1'b0;
        push_req   = 1'b0;
        if (IsUpdate) begin
            if (!len_ok) begin
                drop_word  = 1'b1;
                state_next = WAIT_LEFT;
            end else begin
                case (state)
                    WAIT_LEFT: begin
                        if (IsLeft) begin
                            load_held  = 1'b1;
                            state_next = WAIT_RIGHT;
                        end else begin
                            drop_word = 1'b1;
                        end
                    end
                    default: begin
                        if (IsLeft) begin
                            load_held = 1'b1;
                            drop_word = 1'b1;
                        end else if (len == held_len) begin
                            push_req   = 1'b1;
                            state_next = WAIT_LEFT;
                        end else begin
                            drop_word  = 1'b1;
                            state_next = WAIT_LEFT;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= WAIT_LEFT;
            held_left <= '0;
            held_len  <= '0;
        end else begin
            state <= state_next;
            if (load_held) begin
                held_left <= sample;
                held_len  <= len;
            end
        end
    end

    assign OutValid  = count != '0;
    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign pop       = OutValid && OutReady;
    assign push      = push_req && (!full || pop);
    assign ovf_evt   = push_req && full && !pop;
    assign drop_evt  = drop_word || ovf_evt;
    assign FifoLevel = count;

    // When empty the outputs keep showing the most recently consumed frame
    assign OutLeft  = OutValid ? mem_left[rd_ptr]  : last_left;
    assign OutRight = OutValid ? mem_right[rd_ptr] : last_right;

    always_ff @(posedge Clock) begin
        if (push) begin
            mem_left[wr_ptr]  <= held_left;
            mem_right[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_left  <= '0;
            last_right <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                last_left  <= mem_left[rd_ptr];
                last_right <= mem_right[rd_ptr];
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            DropCount <= '0;
            Overflow  <= 1'b0;
        end else if (ClearStatus) begin
            DropCount <= '0;
            Overflow  <= 1'b0;
        end else begin
            if (drop_evt && DropCount != 8'hFF) begin
                DropCount <= DropCount + 8'd1;
            end
            if (ovf_evt) begin
                Overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_stereo_packer.sv
// tb/tb_i2s_stereo_packer.sv - directed and randomized checks of i2s_stereo_packer against a queue-based model
module tb_i2s_stereo_packer;
    localparam int OW    = 24;
    localparam int MINB  = 8;
    localparam int DEPTH = 8;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [31:0]   Audio = '0;
    logic [4:0]    channelBitCount = '0;
    logic          IsLeft = 1'b0;
    logic          IsUpdate = 1'b0;
    logic [OW-1:0] OutLeft, OutRight;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [3:0]    FifoLevel;
    logic [7:0]    DropCount;
    logic          Overflow;
    logic          ClearStatus = 1'b0;

    int checks = 0;
    int errors = 0;

    i2s_stereo_packer #(.OUT_WIDTH(OW), .MIN_BITS(MINB), .FIFO_DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .Audio(Audio), .channelBitCount(channelBitCount),
        .IsLeft(IsLeft), .IsUpdate(IsUpdate), .OutLeft(OutLeft), .OutRight(OutRight),
        .OutValid(OutValid), .OutReady(OutReady), .FifoLevel(FifoLevel),
        .DropCount(DropCount), .Overflow(Overflow), .ClearStatus(ClearStatus)
    );

    always #5 Clock = ~Clock;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [OW-1:0] norm(logic [31:0] a, int l);
        longint v;
        v = longint'(a) & ((64'd1 << l) - 1);
        if (l >= OW) v = v >> (l - OW);
        else         v = v << (OW - l);
        return v[OW-1:0];
    endfunction

    // Model: frames as {left,right}; held left word; drop/overflow status; last consumed frame
    logic [63:0]   mq[$];
    bit            m_wait_right;
    logic [OW-1:0] m_held;
    int            m_hl;
    int            m_drop;
    bit            m_ovf;
    logic [63:0]   m_last;

    always @(negedge Clock) begin
        if (!Reset) begin
            mq.delete();
            m_wait_right = 0; m_held = '0; m_hl = 0; m_drop = 0; m_ovf = 0; m_last = '0;
            chk("rst_valid", OutValid, 0);
            chk("rst_level", FifoLevel, 0);
            chk("rst_left", OutLeft, 0);
            chk("rst_right", OutRight, 0);
            chk("rst_drop", DropCount, 0);
            chk("rst_ovf", Overflow, 0);
        end else begin
            chk("valid", OutValid, mq.size() != 0);
            chk("level", FifoLevel, mq.size());
            chk("left", OutLeft, mq.size() != 0 ? mq[0][63:32] : m_last[63:32]);
            chk("right", OutRight, mq.size() != 0 ? mq[0][31:0] : m_last[31:0]);
            chk("drop", DropCount, m_drop);
            chk("ovf", Overflow, m_ovf);
            begin
                bit drop, ovf_evt, push;
                int l;
                logic [OW-1:0] s;
                logic [63:0] frame;
                drop = 0; ovf_evt = 0; push = 0; frame = '0;
                if (IsUpdate) begin
                    l = int'(channelBitCount) + 1;
                    s = norm(Audio, l);
                    if (l < MINB) begin
                        drop = 1; m_wait_right = 0;
                    end else if (!m_wait_right) begin
                        if (IsLeft) begin m_held = s; m_hl = l; m_wait_right = 1; end
                        else drop = 1;
                    end else if (IsLeft) begin
                        m_held = s; m_hl = l; drop = 1;
                    end else begin
                        if (l == m_hl) begin push = 1; frame = {32'(m_held), 32'(s)}; end
                        else drop = 1;
                        m_wait_right = 0;
                    end
                end
                if (mq.size() != 0 && OutReady) m_last = mq.pop_front();
                if (push) begin
                    if (mq.size() < DEPTH) mq.push_back(frame);
                    else ovf_evt = 1;
                end
                if (ClearStatus) begin
                    m_drop = 0; m_ovf = 0;
                end else begin
                    if ((drop || ovf_evt) && m_drop < 255) m_drop++;
                    if (ovf_evt) m_ovf = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic word(bit left, logic [31:0] a, logic [4:0] cbc);
        IsUpdate = 1; IsLeft = left; Audio = a; channelBitCount = cbc;
        step();
        IsUpdate = 0;
    endtask

    task automatic clear();
        ClearStatus = 1;
        step();
        ClearStatus = 0;
    endtask

    initial begin
        step(); step();
        Reset = 1;
        step();
        chk("init_drop", DropCount, 0);

        OutReady = 1;
        word(1, 32'h8001, 5'd15);
        word(0, 32'h8301, 5'd15);
        chk("pair_valid", OutValid, 1);
        chk("pair_left", OutLeft, 24'h800100);
        chk("pair_right", OutRight, 24'h830100);
        chk("pair_drop", DropCount, 0);
        step();
        chk("pair_one_cycle", OutValid, 0);

        word(1, 32'h15F07712, 5'd31);
        word(0, 32'h16F0FF34, 5'd31);
        chk("trunc_left", OutLeft, 24'h15F077);
        chk("trunc_right", OutRight, 24'h16F0FF);
        step();

        clear();
        word(1, 32'h1, 5'd1);
        chk("short_drop", DropCount, 1);
        word(0, 32'h1234, 5'd15);
        chk("orphan_right", DropCount, 2);
        word(1, 32'h123456, 5'd23);
        word(0, 32'h1234, 5'd15);
        chk("len_mismatch", DropCount, 3);
        chk("len_mismatch_nopush", FifoLevel, 0);

        clear();
        OutReady = 0;
        for (int i = 0; i < 9; i++) begin
            word(1, 32'h1000 + i, 5'd15);
            word(0, 32'h2000 + i, 5'd15);
        end
        chk("ovf_level", FifoLevel, 8);
        chk("ovf_flag", Overflow, 1);
        chk("ovf_drop", DropCount, 1);
        OutReady = 1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_left", OutLeft, 24'((32'h1000 + i) << 8));
            chk("drain_right", OutRight, 24'((32'h2000 + i) << 8));
            step();
        end
        chk("drain_empty", OutValid, 0);
        clear();
        chk("clr_ovf", Overflow, 0);
        chk("clr_drop", DropCount, 0);

        OutReady = 0;
        for (int i = 0; i < 8; i++) begin
            word(1, 32'h3000 + i, 5'd15);
            word(0, 32'h4000 + i, 5'd15);
        end
        word(1, 32'h5555, 5'd15);
        IsUpdate = 1; IsLeft = 0; Audio = 32'h6666; channelBitCount = 5'd15; OutReady = 1;
        step();
        IsUpdate = 0; OutReady = 0;
        chk("fullpop_level", FifoLevel, 8);
        chk("fullpop_ovf", Overflow, 0);
        chk("fullpop_drop", DropCount, 0);
        OutReady = 1;
        repeat (10) step();

        OutReady = 0;
        for (int i = 0; i < 3; i++) begin
            word(1, 32'h7000 + i, 5'd15);
            word(0, 32'h7100 + i, 5'd15);
        end
        word(1, 32'h7777, 5'd15);
        @(posedge Clock);
        #3;
        Reset = 0;
        #1;
        chk("async_valid", OutValid, 0);
        chk("async_level", FifoLevel, 0);
        chk("async_left", OutLeft, 0);
        step();
        Reset = 1;
        step();
        word(0, 32'h4321, 5'd15);
        chk("post_rst_orphan", DropCount, 1);
        OutReady = 1;
        word(1, 32'h1234, 5'd15);
        word(0, 32'hABCD, 5'd15);
        chk("post_rst_left", OutLeft, 24'h123400);
        chk("post_rst_right", OutRight, 24'hABCD00);
        step();

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 9);
            IsUpdate = 1'($urandom_range(0, 1));
            IsLeft = 1'($urandom_range(0, 1));
            Audio = $urandom;
            channelBitCount = (r < 3) ? 5'd15 : (r < 6) ? 5'd23 : (r < 8) ? 5'd31 : 5'($urandom_range(0, 31));
            OutReady = ($urandom_range(0, 9) < 6);
            ClearStatus = ($urandom_range(0, 49) == 0);
            step();
        end
        ClearStatus = 0;
        for (int n = 0; n < 2000; n++) begin
            IsUpdate = 1;
            IsLeft = 1'($urandom_range(0, 1));
            Audio = $urandom;
            channelBitCount = ($urandom_range(0, 1) != 0) ? 5'd15 : 5'($urandom_range(0, 31));
            OutReady = ($urandom_range(0, 3) == 0);
            step();
        end
        IsUpdate = 0;
        OutReady = 1;
        repeat (12) step();
        chk("final_empty", OutValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_stereo_packer.md
Name: i2s_stereo_packer

Overview:
- Sits directly downstream of i2s_rx.
- Consumes its per-channel word strobes (Audio, channelBitCount, IsLeft, IsUpdate) and normalises every sample to a fixed MSB-aligned width.
- Pairs each left word with the following right word and buffers complete stereo frames in a small FIFO.
- Presents frames to the DSP/DMA side over a valid/ready handshake, with drop and overflow status.

Parameters:
- OUT_WIDTH, 24, bits per output sample (8..32).
- MIN_BITS, 8, smallest accepted received word length; shorter words are rejected.
- FIFO_DEPTH, 8, stereo frames buffered; power of two, 2..64.

Ports:
- Clock  in  1  system clock, all logic rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Audio  in  32  received word from i2s_rx, right-justified in Audio[L-1:0].
- channelBitCount  in  5  received word length minus one (L = channelBitCount+1, 1..32).
- IsLeft  in  1  qualifies IsUpdate: 1 = left word, 0 = right word.
- IsUpdate  in  1  one-cycle strobe; Audio, channelBitCount and IsLeft are valid this cycle.
- OutLeft  out  OUT_WIDTH  head-of-FIFO left sample.
- OutRight  out  OUT_WIDTH  head-of-FIFO right sample.
- OutValid  out  1  FIFO not empty.
- OutReady  in  1  consumer accepts the frame when OutValid && OutReady.
- FifoLevel  out  clog2(FIFO_DEPTH)+1  stored frame count.
- DropCount  out  8  saturating count of discarded words/frames.
- Overflow  out  1  sticky; set when a complete frame is lost to a full FIFO.
- ClearStatus  in  1  synchronous; clears DropCount and Overflow.

Behaviour:
- Reset (Reset=0, async), applies immediately, including mid-frame or mid-transfer:
  - FSM goes to WAIT_LEFT and the held left sample clears.
  - FIFO empties.
  - Outputs: OutValid=0, FifoLevel=0, OutLeft=OutRight=0, DropCount=0, Overflow=0.
- Normalisation, combinational on the input word:
  - If L >= OUT_WIDTH: sample = Audio[L-1 -: OUT_WIDTH]; low bits are truncated, no rounding.
  - Else: sample = Audio[L-1:0] << (OUT_WIDTH-L), zero-filled.
  - The sign bit always lands in the output MSB.
- Validity: a word with L < MIN_BITS is rejected. It counts one drop and forces the FSM to WAIT_LEFT.
- FSM, evaluated only on a valid IsUpdate:
  - WAIT_LEFT, left word: store the sample and its L, go to WAIT_RIGHT.
  - WAIT_LEFT, right word: drop (orphan right), +1 DropCount, stay.
  - WAIT_RIGHT, right word with the same L: form frame {held left, this sample}, push, go to WAIT_LEFT.
  - WAIT_RIGHT, right word with a different L: drop the pair, +1 DropCount, go to WAIT_LEFT.
  - WAIT_RIGHT, left word: replace the held left (previous left orphaned), +1 DropCount, stay in WAIT_RIGHT.
- Push latency: the frame is written on the same edge that samples the right IsUpdate. OutValid, FifoLevel and the outputs update immediately after that edge, so data is visible 1 clock after the strobe cycle.
- FIFO: first-word fall-through; OutLeft/OutRight always show the head entry and hold their value when empty.
  - Pop occurs on any edge with OutValid && OutReady.
  - Push and pop in the same edge are both performed, with FifoLevel unchanged.
  - Push when full with no pop in the same edge: frame discarded, Overflow set, +1 DropCount.
  - Push when full with a pop in the same edge: frame is accepted.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- DropCount saturates at 255.
- ClearStatus takes priority over a same-cycle increment: the result is 0.
- OutReady while OutValid=0 has no effect.
- IsUpdate is a strobe. Back-to-back strobes in consecutive cycles must each be processed.

Test Plan:
- Pairing (OUT_WIDTH=24): left 16'h8001 then right 16'h8301, both L=16, OutReady=1 → one frame OutLeft=24'h800100, OutRight=24'h830100, OutValid high for exactly 1 cycle, DropCount=0.
- Truncation: left 32'h15F07712 and right 32'h16F0FF34, both L=32 → OutLeft=24'h15F077, OutRight=24'h16F0FF.
- Rejection/orphans:
  - 2-bit left 2'b01 → DropCount+1.
  - A right word alone in WAIT_LEFT → DropCount+1.
  - Left L=24 followed by right L=16 → pair dropped, DropCount+1, no frame pushed.
- Overflow: OutReady=0, push 9 valid pairs → FifoLevel=8, Overflow=1, DropCount=1. Then raise OutReady → 8 frames drain in order, the first equal to the first pushed. Then ClearStatus → Overflow=0, DropCount=0.
- Full with concurrent pop: FIFO full and OutReady=1 on the push edge → frame accepted, FifoLevel stays 8, Overflow stays 0.
- Reset mid-operation: assert Reset low after a left word, 3 frames queued → OutValid=0 and FifoLevel=0 immediately. After release, a right word alone is dropped and a fresh left/right pair yields a correct frame.
